// File: rtl/hins_fog_ctrl_bank.sv
// FOG channel control bank: PLL-lock reset sequencer plus shadow/active parameter registers.
// Optional readback port: define HINS_PARAM_READBACK_EN.
module hins_fog_ctrl_bank #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     pll_clk_cpu_int,
  input  logic                     RST_EXT_N,
  input  logic                     i_pll_locked,
  output logic                     o_rst_sync_n,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [CH_W-1:0]          i_wr_ch,
  input  logic [3:0]               i_wr_idx,
  input  logic [31:0]              i_wr_data,
  output logic                     o_wr_err,
  input  logic                     i_commit,
  output logic                     o_commit_done,
  output logic [NUM_CH*11*32-1:0]  o_params
`ifdef HINS_PARAM_READBACK_EN
  ,
  input  logic                     i_rd_valid,
  input  logic [CH_W-1:0]          i_rd_ch,
  input  logic [3:0]               i_rd_idx,
  output logic                     o_rd_valid,
  output logic [31:0]              o_rd_data
`endif
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CH_W:0] LP_NUM_CH = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_ASSERT    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [HC_W-1:0]        r_hold_cnt;
  logic                   r_run;
  logic                   r_wr_err;
  logic                   r_commit_done;
  logic [31:0]            r_shadow [NUM_CH][11];
  logic [31:0]            r_active [NUM_CH][11];

  logic                   w_lock;
  logic                   w_acc;
  logic                   w_bad;
  logic                   w_wr_ok;
  logic                   w_commit;
  logic [31:0]            w_wr_val;
  logic                   w_hit [NUM_CH][11];

  function automatic logic [31:0] f_dflt(input int k);
    case (k)
      0:       return 32'd1000;
      1, 2:    return 32'd5000;
      4:       return 32'd50;
      6, 8:    return 32'd10;
      7:       return 32'd5;
      9:       return 32'd1;
      10:      return 32'd100;
      default: return 32'd0;
    endcase
  endfunction

  // Flag-type indices keep only bit 0; gain selectors clamp to their 5-bit range.
  function automatic logic [31:0] f_conv(input logic [3:0] idx, input logic [31:0] d);
    case (idx)
      4'd3, 4'd9:       return {31'd0, d[0]};
      4'd6, 4'd7, 4'd8: return (d > 32'd31) ? 32'd31 : d;
      default:          return d;
    endcase
  endfunction

  assign w_lock   = r_sync[SYNC_STAGES-1];
  assign w_acc    = i_wr_valid && r_run;
  assign w_bad    = ({1'b0, i_wr_ch} >= LP_NUM_CH) || (i_wr_idx > 4'd10);
  assign w_wr_ok  = w_acc && !w_bad;
  assign w_commit = i_commit && (r_state == S_RUN);
  assign w_wr_val = f_conv(i_wr_idx, i_wr_data);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 11; k++) begin
        w_hit[c][k] = 1'b0;
        if (w_wr_ok && (i_wr_ch == CH_W'(c)) && (i_wr_idx == 4'(k)))
          w_hit[c][k] = 1'b1;
      end
    end
  end

  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_locked};
    end
  end

  // r_run is the registered reset release; it changes on the same edge as r_state.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      r_state    <= S_ASSERT;
      r_hold_cnt <= '0;
      r_run      <= 1'b0;
    end else begin
      case (r_state)
        S_ASSERT: begin
          r_state <= S_WAIT_LOCK;
          r_run   <= 1'b0;
        end
        S_WAIT_LOCK: begin
          if (w_lock) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (!w_lock) begin
            r_state <= S_ASSERT;
          end else if (r_hold_cnt == HC_W'(HOLD_CYCLES-1)) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: begin
          if (!w_lock) begin
            r_state <= S_ASSERT;
            r_run   <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      r_wr_err      <= 1'b0;
      r_commit_done <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 11; k++) begin
          r_shadow[c][k] <= f_dflt(k);
          r_active[c][k] <= f_dflt(k);
        end
      end
    end else begin
      r_wr_err      <= w_acc && w_bad;
      r_commit_done <= w_commit;
      // A write landing with the commit is forwarded straight into active.
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 11; k++) begin
          if (w_hit[c][k])
            r_shadow[c][k] <= w_wr_val;
          if (w_commit)
            r_active[c][k] <= w_hit[c][k] ? w_wr_val : r_shadow[c][k];
        end
      end
    end
  end

  assign o_rst_sync_n  = r_run;
  assign o_wr_ready    = r_run;
  assign o_wr_err      = r_wr_err;
  assign o_commit_done = r_commit_done;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar k = 0; k < 11; k++) begin : g_idx
      assign o_params[(c*11+k)*32 +: 32] = r_active[c][k];
    end
  end

`ifdef HINS_PARAM_READBACK_EN
  logic        r_rd_valid;
  logic [31:0] r_rd_data;
  logic [31:0] w_rd_sel;

  always_comb begin
    w_rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 11; k++) begin
        if ((i_rd_ch == CH_W'(c)) && (i_rd_idx == 4'(k)))
          w_rd_sel = r_shadow[c][k];
      end
    end
  end

  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_valid;
      if (i_rd_valid)
        r_rd_data <= w_rd_sel;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
`endif

endmodule

// File: tb/tb_hins_fog_ctrl_bank.sv
// Directed self-checking bench for hins_fog_ctrl_bank with default parameters.
module tb_hins_fog_ctrl_bank;

  logic          clk;
  logic          rst_n;
  logic          locked;
  logic          rst_sync_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_ch;
  logic [3:0]    wr_idx;
  logic [31:0]   wr_data;
  logic          wr_err;
  logic          commit;
  logic          commit_done;
  logic [1055:0] params;
`ifdef HINS_PARAM_READBACK_EN
  logic          rd_valid_i;
  logic [1:0]    rd_ch;
  logic [3:0]    rd_idx;
  logic          rd_valid_o;
  logic [31:0]   rd_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;

  hins_fog_ctrl_bank dut (
    .pll_clk_cpu_int (clk),
    .RST_EXT_N       (rst_n),
    .i_pll_locked    (locked),
    .o_rst_sync_n    (rst_sync_n),
    .i_wr_valid      (wr_valid),
    .o_wr_ready      (wr_ready),
    .i_wr_ch         (wr_ch),
    .i_wr_idx        (wr_idx),
    .i_wr_data       (wr_data),
    .o_wr_err        (wr_err),
    .i_commit        (commit),
    .o_commit_done   (commit_done),
    .o_params        (params)
`ifdef HINS_PARAM_READBACK_EN
    ,
    .i_rd_valid      (rd_valid_i),
    .i_rd_ch         (rd_ch),
    .i_rd_idx        (rd_idx),
    .o_rd_valid      (rd_valid_o),
    .o_rd_data       (rd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] p(input int c, input int k);
    return params[(c*11+k)*32 +: 32];
  endfunction

  task automatic wr_drive(input logic [1:0] c, input logic [3:0] k, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_ch    = c;
    wr_idx   = k;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Counts edges after the lock input change until o_rst_sync_n reaches the target level.
  task automatic wait_rst(input logic lvl, output int n_out);
    n_out = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (rst_sync_n === lvl) begin
        n_out = n;
        break;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    locked   = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_idx   = '0;
    wr_data  = '0;
    commit   = 1'b0;
`ifdef HINS_PARAM_READBACK_EN
    rd_valid_i = 1'b0;
    rd_ch      = '0;
    rd_idx     = '0;
`endif
    tick();
    tick();
    tick();
    chk("rst_sync_n_in_reset", 32'(rst_sync_n), 32'd0);
    chk("wr_ready_in_reset", 32'(wr_ready), 32'd0);
    chk("wr_err_in_reset", 32'(wr_err), 32'd0);
    chk("commit_done_in_reset", 32'(commit_done), 32'd0);
    chk("dflt_ch2_idx10", p(2, 10), 32'd100);
    chk("dflt_ch1_idx9", p(1, 9), 32'd1);
    chk("dflt_ch1_idx7", p(1, 7), 32'd5);

    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_sync_n_wait_lock", 32'(rst_sync_n), 32'd0);
    // Commit before RUN must be ignored.
    do_commit();
    chk("commit_ignored_pre_run", 32'(commit_done), 32'd0);

    locked = 1'b1;
    wait_rst(1'b1, lat);
    chk("lock_to_release_latency", 32'(lat), 32'd19);
    chk("wr_ready_run", 32'(wr_ready), 32'd1);
    chk("run_ch0_idx0", p(0, 0), 32'd1000);
    chk("run_ch0_idx1", p(0, 1), 32'd5000);

    wr_drive(2'd1, 4'd4, 32'd77);
    chk("shadow_only_ch1_idx4", p(1, 4), 32'd50);
    chk("no_err_valid_write", 32'(wr_err), 32'd0);
    tick();
    chk("shadow_still_ch1_idx4", p(1, 4), 32'd50);
    do_commit();
    chk("commit_ch1_idx4", p(1, 4), 32'd77);
    chk("commit_done_pulse", 32'(commit_done), 32'd1);
    tick();
    chk("commit_done_single", 32'(commit_done), 32'd0);

    // Back-to-back writes with width rules.
    wr_valid = 1'b1;
    wr_ch = 2'd0; wr_idx = 4'd7; wr_data = 32'd100;        tick();
    wr_ch = 2'd0; wr_idx = 4'd3; wr_data = 32'hFFFF_FFFE;  tick();
    wr_ch = 2'd2; wr_idx = 4'd9; wr_data = 32'd2;          tick();
    wr_ch = 2'd2; wr_idx = 4'd6; wr_data = 32'd20;         tick();
    wr_ch = 2'd1; wr_idx = 4'd3; wr_data = 32'd3;          tick();
    wr_ch = 2'd0; wr_idx = 4'd0; wr_data = 32'd1;          tick();
    wr_ch = 2'd0; wr_idx = 4'd0; wr_data = 32'd2;          tick();
    wr_ch = 2'd0; wr_idx = 4'd0; wr_data = 32'd3;          tick();
    wr_valid = 1'b0;
    do_commit();
    chk("sat_ch0_idx7", p(0, 7), 32'd31);
    chk("bit0_ch0_idx3", p(0, 3), 32'd0);
    chk("bit0_ch2_idx9", p(2, 9), 32'd0);
    chk("nosat_ch2_idx6", p(2, 6), 32'd20);
    chk("bit0_ch1_idx3", p(1, 3), 32'd1);
    chk("last_wins_ch0_idx0", p(0, 0), 32'd3);

    wr_drive(2'd3, 4'd0, 32'd9);
    chk("err_bad_ch", 32'(wr_err), 32'd1);
    tick();
    chk("err_pulse_end", 32'(wr_err), 32'd0);
    wr_drive(2'd0, 4'd11, 32'd9);
    chk("err_bad_idx", 32'(wr_err), 32'd1);
    do_commit();
    chk("bad_write_ch0_idx0", p(0, 0), 32'd3);
    chk("bad_write_ch0_idx3", p(0, 3), 32'd0);
    chk("bad_write_ch1_idx0", p(1, 0), 32'd1000);
    chk("bad_write_ch2_idx0", p(2, 0), 32'd1000);

    // Write and commit in the same cycle.
    wr_valid = 1'b1; wr_ch = 2'd2; wr_idx = 4'd10; wr_data = 32'd555;
    commit = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit = 1'b0;
    chk("wr_with_commit_ch2_idx10", p(2, 10), 32'd555);
`ifdef HINS_PARAM_READBACK_EN
    rd_valid_i = 1'b1; rd_ch = 2'd2; rd_idx = 4'd10;
    tick();
    chk("rd_valid", 32'(rd_valid_o), 32'd1);
    chk("rd_ch2_idx10", rd_data, 32'd555);
    rd_ch = 2'd3; rd_idx = 4'd0;
    tick();
    rd_valid_i = 1'b0;
    chk("rd_out_of_range", rd_data, 32'd0);
`endif

    // Lock loss: release drops, registers retained, writes refused.
    locked = 1'b0;
    wait_rst(1'b0, lat);
    chk("lock_loss_latency", 32'(lat), 32'd3);
    chk("wr_ready_lock_loss", 32'(wr_ready), 32'd0);
    chk("retain_ch1_idx4", p(1, 4), 32'd77);
    chk("retain_ch2_idx10", p(2, 10), 32'd555);
    tick();
    wr_valid = 1'b1; wr_ch = 2'd1; wr_idx = 4'd4; wr_data = 32'd999;
    commit = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit = 1'b0;
    chk("refused_no_err", 32'(wr_err), 32'd0);
    chk("commit_ignored_lost", 32'(commit_done), 32'd0);
    chk("refused_ch1_idx4", p(1, 4), 32'd77);

    locked = 1'b1;
    wait_rst(1'b1, lat);
    chk("relock_latency", 32'(lat), 32'd19);
    do_commit();
    chk("shadow_kept_ch1_idx4", p(1, 4), 32'd77);
    chk("commit_after_relock", 32'(commit_done), 32'd1);

    // Asynchronous reset between edges restores defaults immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sync_n", 32'(rst_sync_n), 32'd0);
    chk("async_wr_ready", 32'(wr_ready), 32'd0);
    chk("async_dflt_ch1_idx4", p(1, 4), 32'd50);
    chk("async_dflt_ch0_idx7", p(0, 7), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
